// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store stage between the ALU and a req/gnt/rvalid data
//   memory port. It latches one access from IDLE and drives the memory
//   request. Load data is returned sign- or zero-extended. busy stays high
//   until the access retires. Illegal or misaligned accesses and memory
//   timeouts are reported as faults.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   start             issue strobe, sampled only while idle
//   is_store, funct3  access kind and RV32I width/sign field
//   addr, wdata       effective address and store data (rs2)
//   busy              high whenever an access is in flight (core stall)
//   done              one-cycle completion pulse
//   rdata             extended load data, held until the next load retires
//   fault             {timeout, misaligned_or_illegal}, valid with done
//   mem_req/we/addr/wstrb/wdata   request side of the memory port
//   mem_gnt, mem_rvalid, mem_rdata response side of the memory port
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;
  logic               is_store_q, is_store_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         fault_q, fault_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  // Unsupported funct3 encodings and width-misaligned addresses.
  function automatic logic access_bad(input logic st, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal;
    logic misal;
    if (st) begin
      illegal = (f3[2] == 1'b1) || (f3[1:0] == 2'b11);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    misal = ((f3[1:0] == 2'b01) && (off[0] == 1'b1)) ||
            ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misal;
  endfunction

  // Byte enables for a store at byte offset off.
  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data is replicated across lanes so the strobes alone pick the target bytes.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // The counter covers REQ and WAIT together. The >= compare still ends a
  // load that was granted on the last allowed cycle.
  assign cnt_inc     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_hit = (cnt_inc >= CNT_W'(TIMEOUT));

  // Next-state, timeout and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fault_d     = 2'b00;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          if (access_bad(is_store, funct3, addr[1:0])) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            fault_d = 2'b01;
          end else begin
            state_d     = S_REQ;
            cnt_d       = {CNT_W{1'b0}};
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = is_store ? store_strb(funct3[1:0], addr[1:0]) : 4'b0000;
            mem_wdata_d = is_store ? store_data(funct3[1:0], wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (is_store_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          done_d    = 1'b1;
          fault_d   = 2'b10;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          rdata_d = load_extend(funct3_q, off_q, mem_rdata);
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fault_d = 2'b10;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 2'b00;
      rdata_q     <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit.
// A stimulus process issues accesses and queues the expected outcome from a
// reference model. A responder process acts as the memory. A monitor
// process pops the queue and compares it on every done pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  fault;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  fault;
    logic [31:0] rdata;
    int          done_cyc;
    bit          req;
    bit          st;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  // memory behaviour knobs set by the stimulus
  int          gnt_delay = 0;
  int          rv_delay = 1;
  logic [31:0] rword = 32'h0;
  bit          gnt_never = 1'b0;
  bit          noise = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: legality from the ISA rules, size in bytes
  function automatic bit model_bad(input bit st, input logic [2:0] f3, input logic [1:0] off);
    bit legal;
    int sz;
    if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(off) % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (word >> (8 * int'(off))) & 32'hFF;
      if (f3[2] == 1'b0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3[1:0] == 2'd1) begin
      v = (word >> (16 * (int'(off) / 2))) & 32'hFFFF;
      if (f3[2] == 1'b0 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Issue one access, queue its expected outcome, wait for the unit to go idle.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rd,
                       input logic [31:0] word, input bit never, input bit extra,
                       input bit nz);
    exp_t e;
    bit bad;
    int lat;
    int sz;
    gnt_delay = gd; rv_delay = rd; rword = word; gnt_never = never; noise = nz;
    bad = model_bad(st, f3, a[1:0]);
    sz = 1 << f3[1:0];
    e.req   = !bad;
    e.st    = st;
    e.addr  = a & ~32'h3;
    e.strb  = !st ? 4'd0 : (sz == 4) ? 4'hF : 4'((sz == 1 ? 1 : 3) << int'(a[1:0]));
    e.wdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
              (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    e.rdata = last_rdata;
    e.fault = 2'b00;
    if (bad) begin
      e.fault = 2'b01; lat = 1;
    end else if (never) begin
      e.fault = 2'b10; lat = 17;
    end else if (st) begin
      lat = 2 + gd;
    end else begin
      lat = 2 + gd + rd;
      e.rdata = model_load(f3, a[1:0], word);
      last_rdata = e.rdata;
    end
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    e.done_cyc = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (extra) begin
      // held start with different fields lands in REQ/ERR and must be ignored
      is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("busy_release", {31'd0, busy}, 32'd0);
  endtask

  // Abort an access with an asynchronous reset, either in REQ or in WAIT.
  task automatic reset_mid(input bit in_req);
    gnt_never = in_req; gnt_delay = 0; rv_delay = 30; noise = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_req", {31'd0, mem_req}, {31'd0, in_req});
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_req", {31'd0, mem_req}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    exp_q.delete(); obs_q.delete(); last_rdata = 32'h0; gnt_never = 1'b0;
    rst_n = 1'b1;
  endtask

  // Memory responder: grants after gnt_delay extra REQ cycles, answers loads rv_delay later.
  initial begin
    int   req_cyc;
    int   wait_cnt;
    bit   pending;
    obs_t first;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    req_cyc = 0; wait_cnt = 0; pending = 1'b0;
    first = '{32'h0, 1'b0, 4'h0, 32'h0};
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (!rst_n) begin
        req_cyc = 0; pending = 1'b0;
      end else begin
        if (pending) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rword; pending = 1'b0;
          end
        end
        if (mem_req) begin
          req_cyc++;
          if (req_cyc == 1) begin
            first = '{mem_addr, mem_we, mem_wstrb, mem_wdata};
            obs_q.push_back(first);
          end else begin
            chk("stable_addr", mem_addr, first.addr);
            chk("stable_strb", {28'd0, mem_wstrb}, {28'd0, first.strb});
            chk("stable_wdata", mem_wdata, first.wdata);
          end
          if (noise) begin
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
          end
          if (!gnt_never && req_cyc == gnt_delay + 1) begin
            mem_gnt = 1'b1;
            if (!mem_we) begin
              pending = 1'b1; wait_cnt = rv_delay;
            end
          end
        end else begin
          req_cyc = 0;
        end
      end
    end
  end

  // Monitor: compare every done pulse against the oldest queued expectation.
  initial begin
    exp_t e;
    obs_t o;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending access (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("fault", {30'd0, fault}, {30'd0, e.fault});
            chk("rdata", rdata, e.rdata);
            chk("latency", cyc, e.done_cyc);
            if (e.req) begin
              if (obs_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_req_missing: got no request expected addr %h", e.addr);
              end else begin
                o = obs_q.pop_front();
                chk("mem_addr", o.addr, e.addr);
                chk("mem_we", {31'd0, o.we}, {31'd0, e.st});
                chk("mem_wstrb", {28'd0, o.strb}, {28'd0, e.strb});
                if (e.st) chk("mem_wdata", o.wdata, e.wdata);
              end
            end else begin
              chk("no_mem_req", obs_q.size(), 32'd0);
            end
          end
        end else if (fault !== 2'b00) begin
          chk("fault_without_done", {30'd0, fault}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  legal_ld[5];
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_fault", {30'd0, fault}, 32'd0);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // SB addr 0x103, wdata 0xAB, zero-wait grant
    issue(1'b1, 3'b000, 32'h103, 32'hAB, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
    // LB / LBU from 0x202 reading 0x00800000
    issue(1'b0, 3'b000, 32'h202, 32'h0, 0, 1, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 3'b100, 32'h202, 32'h0, 0, 1, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    // misaligned LW
    issue(1'b0, 3'b010, 32'h06, 32'h0, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
    // LH with no grant ever: timeout, rdata retained
    issue(1'b0, 3'b001, 32'h10, 32'h0, 0, 1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    // grant withheld 5 cycles, second start while busy, noise on rvalid in REQ
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 3'b001, 32'h402, 32'hBEEF_1234, 5, 1, 32'h0, 1'b0, 1'b1, 1'b0);
    // illegal store funct3
    issue(1'b1, 3'b100, 32'h500, 32'h1, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0);

    reset_mid(1'b1);
    reset_mid(1'b0);
    issue(1'b1, 3'b010, 32'h600, 32'h1122_3344, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = legal_ld[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(st, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(1, 4), $urandom,
            1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
